vr_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one downstream valid/ready channel among MERGE_N upstream requesters.

---
 rtl/vr_pkg.sv | 22 ++
 rtl/rr_priority_pick.sv | 33 +++
 rtl/vr_rr_arbiter.sv | 110 +++++++++++
 tb/tb_vr_rr_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vr_pkg.sv
// Shared helpers for the valid/ready arbiter blocks: index width and one-hot to index encoding.
package vr_pkg;

    localparam int MAX_N = 64;

    function automatic int idxWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // OR-ing the bit positions is exact for a one-hot (or zero) vector of any width up to MAX_N.
    function automatic int unsigned onehotToIdx(input logic [MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | int'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority pick: first request at or above the pointer, wrapping to 0.
module rr_priority_pick
    import vr_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [N-1:0] w_grant;
    logic         w_found;

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!w_found && i_req[(int'(i_ptr) + off) % N]) begin
                w_grant[(int'(i_ptr) + off) % N] = 1'b1;
                w_found = 1'b1;
            end
        end
    end

    assign o_grant = w_grant;
    assign o_any   = w_found;
    assign o_idx   = IDX_W'(onehotToIdx(MAX_N'(w_grant)));

endmodule

// File: rtl/vr_rr_arbiter.sv
// Round-robin valid/ready arbiter with a registered output stage.
// Defining VR_ARB_LOCK_EN adds i_last and holds the grant on one requester until its last beat.
module vr_rr_arbiter
    import vr_pkg::*;
#(
    parameter  int MERGE_N = 8,
    parameter  int DATA_W  = 32,
    localparam int IDX_W   = idxWidth(MERGE_N)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MERGE_N-1:0]          i_en,
    input  logic [MERGE_N-1:0]          i_valid,
`ifdef VR_ARB_LOCK_EN
    input  logic [MERGE_N-1:0]          i_last,
`endif
    input  logic [MERGE_N*DATA_W-1:0]   i_data,
    output logic [MERGE_N-1:0]          o_ready,
    output logic                        o_valid,
    output logic [DATA_W-1:0]           o_data,
    output logic [IDX_W-1:0]            o_src,
    input  logic                        i_ready
);

    logic [MERGE_N-1:0] w_req;
    logic [MERGE_N-1:0] w_grant;
    logic [MERGE_N-1:0] w_elig;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_nextPtr;
    logic               w_any;
    logic               w_load;
    logic               w_xfer;

    logic [IDX_W-1:0]   r_ptr;
    logic               r_valid;
    logic [DATA_W-1:0]  r_data;
    logic [IDX_W-1:0]   r_src;

`ifdef VR_ARB_LOCK_EN
    logic               r_lock;
    logic [IDX_W-1:0]   r_lockIdx;
    logic               w_lockHeld;

    // A lock only holds while its owner stays enabled; dropping i_en releases it at once.
    assign w_lockHeld = r_lock & i_en[r_lockIdx];
    assign w_elig     = w_lockHeld ? (MERGE_N'(1) << r_lockIdx) : '1;
`else
    assign w_elig     = '1;
`endif

    assign w_req = i_valid & i_en & w_elig;

    rr_priority_pick #(
        .N     (MERGE_N),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_load    = ~r_valid | i_ready;
    assign w_xfer    = w_load & w_any & ~rst;
    assign w_nextPtr = (w_idx == IDX_W'(MERGE_N - 1)) ? '0 : w_idx + 1'b1;
    assign o_ready   = w_xfer ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_src     <= '0;
`ifdef VR_ARB_LOCK_EN
            r_lock    <= 1'b0;
            r_lockIdx <= '0;
`endif
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= i_data[int'(w_idx)*DATA_W +: DATA_W];
            r_src   <= w_idx;
`ifdef VR_ARB_LOCK_EN
            if (i_last[w_idx]) begin
                r_lock <= 1'b0;
                r_ptr  <= w_nextPtr;
            end else begin
                r_lock    <= 1'b1;
                r_lockIdx <= w_idx;
            end
`else
            r_ptr   <= w_nextPtr;
`endif
        end else begin
            if (i_ready) begin
                r_valid <= 1'b0;
            end
`ifdef VR_ARB_LOCK_EN
            if (!w_lockHeld) begin
                r_lock <= 1'b0;
            end
`endif
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_src   = r_src;

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Randomised and directed checks of vr_rr_arbiter (MERGE_N=4) against a per-transfer reference model.
module tb_vr_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    i_en;
    logic [N-1:0]    i_valid;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    o_ready;
    logic            o_valid;
    logic [DW-1:0]   o_data;
    logic [1:0]      o_src;
    logic            i_ready;
`ifdef VR_ARB_LOCK_EN
    logic [N-1:0]    i_last;
`endif

    int nChecks = 0;
    int nPass   = 0;

    // Reference state: what the output register holds and where round robin resumes.
    int          mPtr   = 0;
    logic        mValid = 1'b0;
    logic [DW-1:0] mData = '0;
    int          mSrc   = 0;

    vr_rr_arbiter #(
        .MERGE_N (N),
        .DATA_W  (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_en    (i_en),
        .i_valid (i_valid),
`ifdef VR_ARB_LOCK_EN
        .i_last  (i_last),
`endif
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_src   (o_src),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Build the candidate order starting at the pointer and take the first one that is asking.
    function automatic int pickWinner(input logic [N-1:0] req, input int ptr);
        int order[$];
        for (int off = 0; off < N; off++) begin
            order.push_back((ptr + off) % N);
        end
        foreach (order[j]) begin
            if (req[order[j]]) begin
                return order[j];
            end
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [N-1:0] e,
                                 input logic rdy, input logic [N*DW-1:0] d);
        int            k;
        logic          canLoad;
        logic [N-1:0]  expReady;
        @(negedge clk);
        rst     = r;
        i_valid = v;
        i_en    = e;
        i_ready = rdy;
        i_data  = d;
`ifdef VR_ARB_LOCK_EN
        i_last  = '1;
`endif
        #1;
        k        = pickWinner(v & e, mPtr);
        canLoad  = !mValid || rdy;
        expReady = (!r && canLoad && k >= 0) ? N'(1 << k) : '0;
        checkOutput("ready", 64'(o_ready), 64'(expReady));
        @(posedge clk);
        if (r) begin
            mValid = 1'b0;
            mData  = '0;
            mSrc   = 0;
            mPtr   = 0;
        end else if (expReady != '0) begin
            mValid = 1'b1;
            mData  = d[k*DW +: DW];
            mSrc   = k;
            mPtr   = (k + 1) % N;
        end else if (rdy) begin
            mValid = 1'b0;
        end
        #1;
        checkOutput("valid", 64'(o_valid), 64'(mValid));
        checkOutput("src",   64'(o_src),   64'(mSrc));
        checkOutput("data",  64'(o_data),  64'(mData));
    endtask

    function automatic logic [N*DW-1:0] laneData(input int base);
        logic [N*DW-1:0] d;
        for (int k = 0; k < N; k++) begin
            d[k*DW +: DW] = DW'(base + k);
        end
        return d;
    endfunction

    initial begin
        rst = 1'b1; i_en = '0; i_valid = '0; i_ready = 1'b0; i_data = '0;
`ifdef VR_ARB_LOCK_EN
        i_last = '1;
`endif
        // Reset state, with o_ready held low even though requests are present.
        applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1, laneData(0));
        applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b1, laneData(0));
        checkOutput("rstValid", 64'(o_valid), 64'd0);
        checkOutput("rstSrc",   64'(o_src),   64'd0);

        // Everyone valid, sink always ready: 0,1,2,3,0,... with no bubbles.
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, laneData(0));
            checkOutput("rrSeq", 64'(o_src), 64'(c % N));
        end

        // Reset while the output register is full, then the next grant restarts at 0.
        applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b0, laneData(16));
        applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0, laneData(16));
        checkOutput("midRstValid", 64'(o_valid), 64'd0);
        applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, laneData(32));
        checkOutput("postRstSrc", 64'(o_src), 64'd0);

        // Backpressure: requester 1 holds the output, then requester 3 follows.
        applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b1, '0);
        applyStimulus(1'b0, 4'b1010, 4'b1111, 1'b1, laneData(48));
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b1010, 4'b1111, 1'b0, laneData(64));
            checkOutput("holdSrc", 64'(o_src), 64'd1);
        end
        applyStimulus(1'b0, 4'b1010, 4'b1111, 1'b1, laneData(80));
        checkOutput("afterHold", 64'(o_src), 64'd3);

        // Requester 3 disabled while valid.
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0, 4'b1111, 4'b0111, 1'($urandom_range(1)), laneData(c));
            checkOutput("noGrant3", 64'(o_ready[3]), 64'd0);
        end

        // Idle stretch, then a lone request on 2.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 4'b0000, 4'b1111, 1'b1, laneData(c));
        end
        checkOutput("idleValid", 64'(o_valid), 64'd0);
        applyStimulus(1'b0, 4'b0100, 4'b1111, 1'b1, laneData(96));
        checkOutput("loneSrc", 64'(o_src), 64'd2);

        // Random traffic.
        for (int c = 0; c < 300; c++) begin
            applyStimulus(($urandom_range(49) == 0), N'($urandom), N'($urandom | $urandom),
                          ($urandom_range(3) != 0), {$urandom, $urandom});
        end

`ifdef VR_ARB_LOCK_EN
        begin
            logic [N-1:0] lastPat [6] = '{4'b1111, 4'b1101, 4'b1101, 4'b1111, 4'b1111, 4'b1111};
            logic [N-1:0] validPat[6] = '{4'b0001, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
            int           expSrc  [6] = '{0, 1, 1, 1, 2, 0};
            @(negedge clk);
            rst = 1'b1; i_valid = '0; i_en = '1; i_ready = 1'b1; i_last = '1;
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                i_valid = validPat[c];
                i_last  = lastPat[c];
                @(posedge clk);
                #1;
                checkOutput("lockSrc", 64'(o_src), 64'(expSrc[c]));
            end
        end
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
